// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetch_unit_pkg;

  // Opcode field values seen by decode
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;

  // addi x0,x0,0 : what decode sees when IF/ID holds a bubble
  localparam logic [31:0] NOP_INS_ENC = 32'h00000013;

  // Clears the byte offset of a branch target
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// Latency: n/a (wiring only).
// Backpressure: imem_ready accepts a request; id_stall holds IF/ID.
// Ports: master = fetch unit side, slave = memory/decode/EX side.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ins;
  logic [6:0]  id_opcode;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_ins, id_opcode,
    input  imem_ready, imem_rvalid, imem_rdata, id_stall,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_ins, id_opcode,
    output imem_ready, imem_rvalid, imem_rdata, id_stall,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds one instruction and its PC for decode.
// Latency: one clock from load_i to valid_o.
// Backpressure: hold_i freezes contents; flush_i beats load_i beats hold_i.
// Ports: clk/rst_n; load_i/hold_i/flush_i controls; pc_i/ins_i data in;
//        valid_o/pc_o/ins_o register contents.
module instr_fetch_unit_if_id_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INS = NOP_INS_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ins_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] ins_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      ins_q   <= NOP_INS;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ins_q   <= NOP_INS;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      ins_q   <= ins_i;
    end else if (!hold_i) begin
      // Decode took the instruction and nothing replaces it: bubble.
      valid_q <= 1'b0;
      ins_q   <= NOP_INS;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign ins_o   = ins_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem request FSM, hold buffer, IF/ID.
// Latency: accept -> rvalid -> IF/ID loaded on the rvalid edge; 1 ins / 2 clk max.
// Backpressure: imem_req waits for imem_ready; id_stall parks data in hold buffer.
// Ports: clk, rst_n (async, active low); bus (master) carries imem_*,
//        id_stall, redirect_* inputs and id_* outputs.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INS  = NOP_INS_ENC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.master    bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_q;

  logic         accept;
  logic         load;
  logic         flush;
  logic [31:0]  load_ins;
  logic         id_valid;
  logic [31:0]  id_pc;
  logic [31:0]  id_ins;

  // The request only counts once imem_req is actually high, so the
  // first cycle out of reset (state REQ, req low) never accepts.
  assign accept = (state_q == ST_REQ) && req_q && bus.imem_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    hold_d   = hold_q;
    load     = 1'b0;
    flush    = 1'b0;
    load_ins = bus.imem_rdata;

    if (bus.redirect_valid) begin
      flush  = 1'b1;
      pc_d   = bus.redirect_pc & PC_ALIGN_MASK;
      hold_d = 32'h0;
      case (state_q)
        ST_REQ: begin
          // Old-pc request already left: its response must be dropped.
          if (accept) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (accept) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else if (!id_valid || !bus.id_stall) begin
              load    = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = ST_REQ;
            end else begin
              hold_d  = bus.imem_rdata;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.id_stall) begin
            load     = 1'b1;
            load_ins = hold_q;
            hold_d   = 32'h0;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      req_q   <= (state_d == ST_REQ);
    end
  end

  // pc only advances after a load, so pc_q is the PC of the word being loaded.
  instr_fetch_unit_if_id_reg #(
    .NOP_INS (NOP_INS)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .hold_i  (bus.id_stall),
    .flush_i (flush),
    .pc_i    (pc_q),
    .ins_i   (load_ins),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .ins_o   (id_ins)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid;
  assign bus.id_pc     = id_pc;
  assign bus.id_ins    = id_ins;
  assign bus.id_opcode = id_ins[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level fetch model plus memory responder.
// Latency: n/a.
// Backpressure: random imem_ready, id_stall and response delay.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Fetch model: "is a request in flight", "is its answer stale",
  // "is a word parked", and the IF/ID contents decode should see.
  bit          m_req, m_out, m_drop, m_held, m_vld;
  logic [31:0] m_pc, m_hbuf, m_idpc, m_ins;

  // Memory responder state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_dly;
  int          dly_min = 0, dly_max = 0;
  bit          rnd_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'hFE000EE3;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_out = 0; m_drop = 0; m_held = 0; m_vld = 0;
    m_pc = 32'h0; m_hbuf = 32'h0; m_idpc = 32'h0; m_ins = NOP;
  endtask

  task automatic deliver(input logic [31:0] data);
    m_vld  = 1;
    m_idpc = m_pc;
    m_ins  = data;
    m_pc   = m_pc + 32'd4;
  endtask

  // Applies one clock edge of the fetch rules to the model.
  task automatic model_update();
    bit acc;
    bit loaded;
    acc = m_req && bus.imem_ready;
    loaded = 0;
    if (bus.redirect_valid) begin
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      m_vld = 0; m_ins = NOP; m_held = 0;
      if (acc) begin
        m_out = 1; m_drop = 1;
      end else if (m_out) begin
        if (bus.imem_rvalid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (acc) m_out = 1;
      else if (m_out && bus.imem_rvalid) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (!m_vld || !bus.id_stall) begin deliver(bus.imem_rdata); loaded = 1; end
        else begin m_held = 1; m_hbuf = bus.imem_rdata; end
      end else if (m_held && !bus.id_stall) begin
        deliver(m_hbuf); m_held = 0; loaded = 1;
      end
      if (!loaded && !bus.id_stall) begin m_vld = 0; m_ins = NOP; end
    end
    m_req = !m_out && !m_held;
  endtask

  // Memory bookkeeping at the edge, using pre-edge model state.
  task automatic mem_book();
    if (bus.imem_rvalid) mem_pend = 0;
    if (m_req && bus.imem_ready) begin
      mem_pend = 1;
      mem_addr = m_pc;
      mem_dly  = $urandom_range(dly_max, dly_min);
    end
  endtask

  // Drives inputs for the coming cycle.
  task automatic drive_next();
    if (mem_pend && mem_dly == 0) begin
      bus.imem_rvalid = 1;
      bus.imem_rdata  = mem_word(mem_addr);
    end else begin
      bus.imem_rvalid = 0;
      bus.imem_rdata  = $urandom;
      if (mem_pend) mem_dly--;
    end
    bus.imem_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rnd_mode) begin
      bus.id_stall       = ($urandom_range(0, 9) < 3);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = $urandom;
    end else begin
      bus.redirect_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mem_book();
    model_update();
    @(negedge clk);
    drive_next();
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return m_vld;
      1: return m_out;
      default: return m_req;
    endcase
  endfunction

  task automatic wait_model(input int which, input int bound, input string nm);
    int n;
    n = 0;
    while (!cond(which) && n < bound) begin
      tick();
      n++;
    end
    total++;
    if (!cond(which)) begin
      bad++;
      $display("FAIL %s timeout: waited %0d cycles, limit %0d", nm, n, bound);
    end
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("imem_req",  {31'b0, bus.imem_req}, {31'b0, m_req});
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("id_valid",  {31'b0, bus.id_valid}, {31'b0, m_vld});
      chk("id_pc",     bus.id_pc, m_idpc);
      chk("id_ins",    bus.id_ins, m_ins);
      chk("id_opcode", {25'b0, bus.id_opcode}, {25'b0, m_ins[6:0]});
    end
  end

  initial begin
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.id_stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    mem_pend = 0; mem_addr = 0; mem_dly = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst imem_req",  {31'b0, bus.imem_req}, 32'h0);
    chk("rst imem_addr", bus.imem_addr, 32'h0);
    chk("rst id_valid",  {31'b0, bus.id_valid}, 32'h0);
    chk("rst id_pc",     bus.id_pc, 32'h0);
    chk("rst id_ins",    bus.id_ins, NOP);
    chk("rst id_opcode", {25'b0, bus.id_opcode}, 32'h13);
    rst_n = 1;
    drive_next();
    chk_en = 1;

    // First fetch, fastest memory
    wait_model(0, 10, "t1 load");
    chk("t1 id_pc",     bus.id_pc, 32'h0);
    chk("t1 id_ins",    bus.id_ins, 32'h00500093);
    chk("t1 id_opcode", {25'b0, bus.id_opcode}, 32'h13);
    chk("t1 next addr", bus.imem_addr, 32'h4);
    chk("t1 req",       {31'b0, bus.imem_req}, 32'h1);

    // Decode stall for 4 cycles while the next word returns
    bus.id_stall = 1;
    repeat (4) tick();
    chk("t2 held ins", bus.id_ins, 32'h00500093);
    chk("t2 held pc",  bus.id_pc, 32'h0);
    chk("t2 req low",  {31'b0, bus.imem_req}, 32'h0);
    bus.id_stall = 0;
    tick();
    chk("t2 ins",  bus.id_ins, 32'hFE000EE3);
    chk("t2 pc",   bus.id_pc, 32'h4);
    chk("t2 addr", bus.imem_addr, 32'h8);

    // Redirect during WAIT, data arrives later
    dly_min = 2; dly_max = 2;
    wait_model(1, 10, "t3 wait");
    bus.redirect_valid = 1;
    bus.redirect_pc    = 32'h00000102;
    tick();
    chk("t3 id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("t3 id_ins",   bus.id_ins, NOP);
    chk("t3 addr",     bus.imem_addr, 32'h100);
    wait_model(0, 20, "t3 load");
    chk("t3 id_pc",  bus.id_pc, 32'h100);
    chk("t3 id_ins2", bus.id_ins, mem_word(32'h100));

    // Redirect coincident with accept in REQ
    dly_min = 0; dly_max = 0;
    wait_model(2, 10, "t4 req");
    bus.imem_ready     = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc    = 32'h00000200;
    tick();
    chk("t4 req low",  {31'b0, bus.imem_req}, 32'h0);
    chk("t4 addr",     bus.imem_addr, 32'h200);
    tick();
    chk("t4 no stale", {31'b0, bus.id_valid}, 32'h0);
    chk("t4 req",      {31'b0, bus.imem_req}, 32'h1);
    wait_model(0, 10, "t4 load");
    chk("t4 id_pc", bus.id_pc, 32'h200);

    // PC wrap
    wait_model(2, 10, "t5 req");
    bus.imem_ready     = 0;
    bus.redirect_valid = 1;
    bus.redirect_pc    = 32'hFFFFFFFE;
    tick();
    chk("t5 addr", bus.imem_addr, 32'hFFFFFFFC);
    wait_model(0, 10, "t5 load");
    chk("t5 id_pc", bus.id_pc, 32'hFFFFFFFC);
    chk("t5 wrap",  bus.imem_addr, 32'h0);

    // Reset while in WAIT, stray rvalid after release
    dly_min = 3; dly_max = 3;
    wait_model(1, 10, "t6 wait");
    #2 rst_n = 0;
    #1;
    chk("t6 req async",   {31'b0, bus.imem_req}, 32'h0);
    chk("t6 valid async", {31'b0, bus.id_valid}, 32'h0);
    chk("t6 addr async",  bus.imem_addr, 32'h0);
    chk_en = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    mem_dly = 0;
    dly_min = 0; dly_max = 0;
    drive_next();
    chk_en = 1;
    wait_model(0, 10, "t6 load");
    chk("t6 id_pc",  bus.id_pc, 32'h0);
    chk("t6 id_ins", bus.id_ins, 32'h00500093);

    // Random traffic
    dly_min = 0; dly_max = 3;
    rnd_mode = 1;
    repeat (1500) tick();
    rnd_mode = 0;
    bus.id_stall = 0;
    bus.redirect_valid = 0;
    tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
